ochan_rr_sched: RTL and testbench

Per-output-channel scheduler for the router crossbar. Arbitrates four input-buffer requesters for one serial output channel, holds the winner for the whole multi-cycle serial transfer, pops exactly one flit from the winner's receive buffer, and drives that output's crossbar mux. One instance sits in front of each output port (N, E, S, W, L) and replaces the per-port grant/enable/read glue around the stateless round-robin arbiter.

---
 rtl/ochan_rr_sched.sv | 138 +++++++++++++
 tb/tb_ochan_rr_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ochan_rr_sched.sv
// Per-output-channel round-robin scheduler: grants one of four input buffers, launches one flit, holds the
// grant for the whole serial transfer. Optional watchdog on a stuck transfer is enabled by ARB_WDOG_EN.
module ochan_rr_sched #(
    parameter int DATA_W      = 32,
    parameter int WDOG_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] item_in0,
    input  logic [DATA_W-1:0] item_in1,
    input  logic [DATA_W-1:0] item_in2,
    input  logic [DATA_W-1:0] item_in3,
    input  logic              out_busy,
    output logic [3:0]        gnt,
    output logic [3:0]        rd,
    output logic              ena,
    output logic [DATA_W-1:0] item_out,
    output logic              wdog_err
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LAUNCH    = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] HOLD      = 2'd3;

    if (WDOG_CYCLES < 2 || WDOG_CYCLES > 65535) begin : g_wdog_cycles_range
        $error("ochan_rr_sched: WDOG_CYCLES must be in 2..65535");
    end

    logic [1:0] state;
    logic [1:0] ptr;
    logic [1:0] win_idx;
    logic       win_vld;
    logic [1:0] cand;
    logic [1:0] gnt_idx;
    logic       launch_start;
    logic       wdog_fire;

    // Search starts just after the last launcher, so it has lowest priority next time.
    always_comb begin
        // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
        win_idx = ptr;
        win_vld = 1'b0;
        cand    = ptr;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr + 2'(k);
            if (!win_vld && req[cand]) begin
                win_idx = cand;
                win_vld = 1'b1;
            end
        end
    end

    assign gnt_idx      = {gnt[3] | gnt[2], gnt[3] | gnt[1]};
    assign launch_start = (state == IDLE) && !out_busy && win_vld;

    // Launch is only confirmed if the owner is still requesting in the LAUNCH cycle.
    assign ena = (state == LAUNCH) && |(gnt & req);
    assign rd  = gnt & {4{ena}};

    assign item_out = ({DATA_W{gnt[0]}} & item_in0)
                    | ({DATA_W{gnt[1]}} & item_in1)
                    | ({DATA_W{gnt[2]}} & item_in2)
                    | ({DATA_W{gnt[3]}} & item_in3);

`ifdef ARB_WDOG_EN
    logic [15:0] wdog_cnt;

    // Fires on the edge where the count would reach the limit.
    assign wdog_fire = ((state == WAIT_BUSY) || (state == HOLD))
                    && ((wdog_cnt + 16'd1) == 16'(WDOG_CYCLES));

    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
        end else begin
            if (launch_start)
                wdog_cnt <= '0;
            else if ((state == WAIT_BUSY) || (state == HOLD))
                wdog_cnt <= wdog_cnt + 16'd1;
            if (wdog_fire)
                wdog_err <= 1'b1;
        end
    end
`else
    assign wdog_fire = 1'b0;
    assign wdog_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            ptr   <= 2'd3;
        end else if (wdog_fire) begin
            state <= IDLE;
            gnt   <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (launch_start) begin
                        gnt   <= 4'b0001 << win_idx;
                        state <= LAUNCH;
                    end else begin
                        gnt   <= 4'b0000;
                    end
                end
                LAUNCH: begin
                    if (ena) begin
                        ptr   <= gnt_idx;
                        state <= WAIT_BUSY;
                    end else begin
                        gnt   <= 4'b0000;
                        state <= IDLE;
                    end
                end
                WAIT_BUSY: begin
                    if (out_busy)
                        state <= HOLD;
                end
                HOLD: begin
                    if (!out_busy) begin
                        gnt   <= 4'b0000;
                        state <= IDLE;
                    end
                end
                default: begin
                    gnt   <= 4'b0000;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ochan_rr_sched.sv
// Self-checking bench for ochan_rr_sched: a per-cycle owner/phase model plus directed literal checks.
// Covers both builds; the watchdog scenario follows ARB_WDOG_EN.
module tb_ochan_rr_sched;

    localparam int DW = 32;
    localparam int WD = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    req;
    logic [DW-1:0] items [4];
    logic          out_busy;
    logic [3:0]    gnt;
    logic [3:0]    rd;
    logic          ena;
    logic [DW-1:0] item_out;
    logic          wdog_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ochan_rr_sched #(.DATA_W(DW), .WDOG_CYCLES(WD)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .item_in0 (items[0]),
        .item_in1 (items[1]),
        .item_in2 (items[2]),
        .item_in3 (items[3]),
        .out_busy (out_busy),
        .gnt      (gnt),
        .rd       (rd),
        .ena      (ena),
        .item_out (item_out),
        .wdog_err (wdog_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: who owns the output, whether the flit was launched, whether busy was seen.
    int m_owner    = -1;
    bit m_launched = 1'b0;
    bit m_seen     = 1'b0;
    int m_last     = 3;
    int m_wd       = 0;
    bit m_werr     = 1'b0;
    int launch_log [$];

    always @(negedge clk) begin : compare
        logic [3:0]    e_gnt;
        logic          e_ena;
        logic [DW-1:0] e_item;
        bit            found;

        e_gnt  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        e_ena  = (m_owner >= 0) && !m_launched && req[m_owner];
        e_item = (m_owner >= 0) ? items[m_owner] : '0;
        check("gnt", gnt, e_gnt);
        check("ena", ena, e_ena);
        check("rd", rd, e_ena ? e_gnt : 4'b0000);
        check("item_out", item_out, e_item);
        check("wdog_err", wdog_err, m_werr);

        if (ena === 1'b1)
            for (int i = 0; i < 4; i++)
                if (rd[i] === 1'b1) launch_log.push_back(i);

        if (reset) begin
            m_owner = -1; m_launched = 0; m_seen = 0; m_last = 3; m_wd = 0; m_werr = 0;
        end else if (m_owner < 0) begin
            if (!out_busy) begin
                found = 0;
                for (int k = 1; k <= 4; k++)
                    if (!found && req[(m_last + k) % 4]) begin
                        m_owner = (m_last + k) % 4;
                        found   = 1;
                    end
                m_launched = 0; m_seen = 0; m_wd = 0;
            end
        end else if (!m_launched) begin
            if (req[m_owner]) begin
                m_launched = 1;
                m_last     = m_owner;
            end else begin
                m_owner = -1;
            end
        end else begin
            m_wd++;
`ifdef ARB_WDOG_EN
            if (m_wd >= WD) begin
                m_owner = -1;
                m_werr  = 1;
            end else
`endif
            if (!m_seen) begin
                if (out_busy) m_seen = 1;
            end else if (!out_busy) begin
                m_owner = -1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = 4'b0000; out_busy = 1'b0;
        step(1);
        reset = 1'b0;
    endtask

    // Called in the LAUNCH cycle: drop the request, pulse busy, return to IDLE.
    task automatic complete();
        step(1);
        req = 4'b0000; out_busy = 1'b1;
        step(2);
        out_busy = 1'b0;
        step(1);
    endtask

    initial begin : global_timeout
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int  exp_order [5] = '{0, 1, 2, 3, 0};
        bit  seen;

        reset = 1'b1; req = 4'b0000; out_busy = 1'b0;
        items[0] = 32'h1111_0000; items[1] = 32'h2222_0001;
        items[2] = 32'hA5A5_0012; items[3] = 32'h4444_0003;
        step(2);
        reset = 1'b0;
        check("rst_gnt", gnt, 4'b0000);
        check("rst_item", item_out, 32'h0);
        check("rst_wdog", wdog_err, 1'b0);

        // All four requesting: rotation 0,1,2,3,0.
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            seen = 0;
            for (int c = 0; c < 30 && !seen; c++) begin
                if (ena === 1'b1) seen = 1;
                else step(1);
            end
            check("t1_ena_seen", seen, 1'b1);
            step(2);
            out_busy = 1'b1;
            step(3);
            out_busy = 1'b0;
        end
        req = 4'b0000;
        step(2);
        check("t1_count", launch_log.size(), 5);
        for (int i = 0; i < 5 && i < launch_log.size(); i++)
            check($sformatf("t1_launch%0d", i), launch_log[i], exp_order[i]);

        // Single requester and the data mux.
        do_reset();
        req = 4'b0100;
        step(1);
        check("t2_gnt", gnt, 4'b0100);
        check("t2_item", item_out, 32'hA5A5_0012);
        step(1);
        req = 4'b0000; out_busy = 1'b1;
        check("t2_item_hold", item_out, 32'hA5A5_0012);
        step(2);
        out_busy = 1'b0;
        step(1);
        check("t2_gnt_rel", gnt, 4'b0000);
        check("t2_item_rel", item_out, 32'h0);

        // Busy output blocks granting.
        do_reset();
        out_busy = 1'b1; req = 4'b0011;
        step(4);
        check("t3_gnt_busy", gnt, 4'b0000);
        out_busy = 1'b0;
        step(1);
        check("t3_gnt", gnt, 4'b0001);
        complete();

        // Abort in LAUNCH leaves the pointer alone.
        do_reset();
        req = 4'b0010;
        step(1);
        req = 4'b0000;
        step(1);
        check("t4_gnt_abort", gnt, 4'b0000);
        req = 4'b0011;
        step(1);
        check("t4_regrant", gnt, 4'b0001);
        complete();
        req = 4'b0100;
        step(1);
        check("t4_gnt2", gnt, 4'b0100);
        complete();
        req = 4'b0001;
        step(1);
        check("t4_gnt0", gnt, 4'b0001);
        req = 4'b0000;
        step(1);
        req = 4'b1111;
        step(1);
        check("t4_ptr_kept", gnt, 4'b1000);
        complete();

        // Reset during HOLD.
        do_reset();
        req = 4'b1000;
        step(1);
        check("t5_gnt", gnt, 4'b1000);
        step(1);
        req = 4'b0000; out_busy = 1'b1;
        step(1);
        check("t5_hold_gnt", gnt, 4'b1000);
        reset = 1'b1;
        step(1);
        check("t5_rst_gnt", gnt, 4'b0000);
        reset = 1'b0; out_busy = 1'b0; req = 4'b1001;
        step(1);
        check("t5_regrant", gnt, 4'b0001);
        complete();

        // Transmitter never goes busy after the launch.
        do_reset();
        req = 4'b0001;
        step(1);
        step(1);
        req = 4'b0000;
`ifdef ARB_WDOG_EN
        step(7);
        check("t6_gnt_pre", gnt, 4'b0001);
        check("t6_wdog_pre", wdog_err, 1'b0);
        step(1);
        check("t6_gnt_fired", gnt, 4'b0000);
        check("t6_wdog_fired", wdog_err, 1'b1);
        step(3);
        check("t6_wdog_sticky", wdog_err, 1'b1);
        do_reset();
        check("t6_wdog_rst", wdog_err, 1'b0);
`else
        step(100);
        check("t6_gnt_held", gnt, 4'b0001);
        check("t6_wdog_zero", wdog_err, 1'b0);
        out_busy = 1'b1;
        step(2);
        out_busy = 1'b0;
        step(2);
        check("t6_gnt_rel", gnt, 4'b0000);
`endif
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
